booth_mac_accumulator: RTL and testbench

BOOTH_MAC_ACCUMULATOR -- requirements
Module: booth_mac_accumulator

---
 rtl/booth_mac_accumulator.sv | 137 +++++++++++++
 tb/tb_booth_mac_accumulator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : booth_mac_accumulator
//  Purpose  : Waits a fixed latency after an upstream Booth multiplier
//             restart, then adds the signed product into a saturating
//             accumulator and holds the result behind a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module booth_mac_accumulator #(
    parameter int N       = 32,
    parameter int LATENCY = 34,
    parameter int ACC_W   = 72
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr_acc,
    input  logic [2*N-1:0]   prod,
    input  logic             out_ready,
    output logic             busy,
    output logic             out_valid,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic [15:0]      count
);

    localparam int                 C_CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(LATENCY - 1);
    localparam logic [ACC_W-1:0]   C_ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]   C_ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [15:0]        C_CNT_SAT  = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ACCUM = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [15:0]        r_count;
    logic               r_busy;
    logic               r_valid;

    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   w_acc_base;
    logic [ACC_W:0]     w_sum;
    logic               w_pos_ovf;
    logic               w_neg_ovf;
    logic [ACC_W-1:0]   w_acc_sat;
    logic [15:0]        w_count_base;
    logic [15:0]        w_count_inc;
    logic               w_ovf_nxt;

    // A clear coinciding with ACCUM zeroes the old total before the add.
    assign w_prod_ext   = {{(ACC_W-2*N){prod[2*N-1]}}, prod};
    assign w_acc_base   = clr_acc ? '0 : r_acc;
    assign w_sum        = {w_acc_base[ACC_W-1], w_acc_base} + {w_prod_ext[ACC_W-1], w_prod_ext};
    assign w_pos_ovf    = ~w_sum[ACC_W] &  w_sum[ACC_W-1];
    assign w_neg_ovf    =  w_sum[ACC_W] & ~w_sum[ACC_W-1];
    assign w_acc_sat    = w_pos_ovf ? C_ACC_MAX :
                          w_neg_ovf ? C_ACC_MIN : w_sum[ACC_W-1:0];
    assign w_count_base = clr_acc ? 16'd0 : r_count;
    assign w_count_inc  = (w_count_base == C_CNT_SAT) ? w_count_base : w_count_base + 16'd1;
    assign w_ovf_nxt    = (clr_acc ? 1'b0 : r_ovf) | w_pos_ovf | w_neg_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= 16'd0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_WAIT;
                        r_cnt   <= C_CNT_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_ACCUM;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_ACCUM: begin
                    r_state <= S_HOLD;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b1;
                    r_acc   <= w_acc_sat;
                    r_ovf   <= w_ovf_nxt;
                    r_count <= w_count_inc;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        if (start) begin
                            r_state <= S_WAIT;
                            r_cnt   <= C_CNT_LOAD;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase

            if (clr_acc && (r_state != S_ACCUM)) begin
                r_acc   <= '0;
                r_ovf   <= 1'b0;
                r_count <= 16'd0;
            end
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_valid;
    assign acc       = r_acc;
    assign ovf       = r_ovf;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_booth_mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_mac_accumulator
//  Purpose  : Directed self-checking bench for booth_mac_accumulator.
//  Revision : 1.0  initial release
// ============================================================================
module tb_booth_mac_accumulator;

    localparam int LAT     = 34;
    localparam int SAT_LAT = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_start, a_clr, a_ready;
    logic [63:0] a_prod;
    logic        a_busy, a_valid, a_ovf;
    logic [71:0] a_acc;
    logic [15:0] a_count;

    logic        b_start, b_clr, b_ready;
    logic [63:0] b_prod;
    logic        b_busy, b_valid, b_ovf;
    logic [64:0] b_acc;
    logic [15:0] b_count;

    int total = 0;
    int bad   = 0;

    booth_mac_accumulator #(.N(32), .LATENCY(LAT), .ACC_W(72)) u_dut (
        .clk(clk), .rst(rst), .start(a_start), .clr_acc(a_clr), .prod(a_prod),
        .out_ready(a_ready), .busy(a_busy), .out_valid(a_valid), .acc(a_acc),
        .ovf(a_ovf), .count(a_count)
    );

    booth_mac_accumulator #(.N(32), .LATENCY(SAT_LAT), .ACC_W(65)) u_sat (
        .clk(clk), .rst(rst), .start(b_start), .clr_acc(b_clr), .prod(b_prod),
        .out_ready(b_ready), .busy(b_busy), .out_valid(b_valid), .acc(b_acc),
        .ovf(b_ovf), .count(b_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // HOLD is reached one edge after ACCUM, i.e. LATENCY+1 edges after start.
    task automatic run_a(input logic [63:0] p, input string tag);
        int n;
        a_prod  = p;
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        n = 0;
        while (!a_valid && n < 200) begin
            tick;
            n++;
        end
        chk({tag, " latency"}, 72'(n), 72'(LAT + 1));
    endtask

    task automatic hs_a;
        a_ready = 1'b1;
        tick;
        a_ready = 1'b0;
    endtask

    task automatic run_b(input logic [63:0] p, input string tag);
        int n;
        b_prod  = p;
        b_start = 1'b1;
        tick;
        b_start = 1'b0;
        n = 0;
        while (!b_valid && n < 50) begin
            tick;
            n++;
        end
        chk({tag, " latency"}, 72'(n), 72'(SAT_LAT + 1));
        b_ready = 1'b1;
        tick;
        b_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic flag;
        rst = 1'b1;
        a_start = 1'b0; a_clr = 1'b0; a_ready = 1'b0; a_prod = '0;
        b_start = 1'b0; b_clr = 1'b0; b_ready = 1'b0; b_prod = '0;
        tick;
        tick;
        chk("rst busy",  72'(a_busy),  72'd0);
        chk("rst valid", 72'(a_valid), 72'd0);
        chk("rst acc",   a_acc,        72'd0);
        chk("rst ovf",   72'(a_ovf),   72'd0);
        chk("rst count", 72'(a_count), 72'd0);
        rst = 1'b0;

        // Single product, started in the first cycle out of reset
        run_a(64'(-150), "single");
        chk("single acc",   a_acc,        72'(-150));
        chk("single count", 72'(a_count), 72'd1);
        chk("single ovf",   72'(a_ovf),   72'd0);
        chk("single busy",  72'(a_busy),  72'd0);
        hs_a;
        chk("single idle valid", 72'(a_valid), 72'd0);
        chk("single idle busy",  72'(a_busy),  72'd0);

        // Accumulate with back-pressure
        a_clr = 1'b1;
        tick;
        a_clr = 1'b0;
        chk("clr acc",   a_acc,        72'd0);
        chk("clr count", 72'(a_count), 72'd0);
        run_a(64'd6, "bp6");
        chk("bp6 acc", a_acc, 72'd6);
        flag = 1'b1;
        repeat (5) begin
            tick;
            if (a_acc !== 72'd6 || a_valid !== 1'b1) flag = 1'b0;
        end
        chk("stall stable", 72'(flag), 72'd1);
        hs_a;
        run_a(64'(-150), "bp150");
        chk("bp acc",   a_acc,        72'(-144));
        chk("bp count", 72'(a_count), 72'd2);

        // Back-to-back handshake plus a start pulse mid-WAIT that must be dropped
        a_prod  = 64'd5;
        a_ready = 1'b1;
        a_start = 1'b1;
        tick;
        a_ready = 1'b0;
        a_start = 1'b0;
        chk("b2b busy",  72'(a_busy),  72'd1);
        chk("b2b valid", 72'(a_valid), 72'd0);
        n = 0;
        while (!a_valid && n < 200) begin
            a_start = (n == 10);
            tick;
            n++;
        end
        a_start = 1'b0;
        chk("b2b latency", 72'(n), 72'(LAT + 1));
        chk("b2b acc",     a_acc,        72'(-139));
        chk("b2b count",   72'(a_count), 72'd3);
        hs_a;
        flag = 1'b0;
        repeat (40) begin
            tick;
            if (a_valid || a_busy) flag = 1'b1;
        end
        chk("no queued start", 72'(flag), 72'd0);

        // Reset in the 12th cycle of WAIT
        a_prod  = 64'd99;
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        repeat (11) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst busy",  72'(a_busy),  72'd0);
        chk("midrst valid", 72'(a_valid), 72'd0);
        chk("midrst acc",   a_acc,        72'd0);
        run_a(64'd7, "after rst");
        chk("after rst acc",   a_acc,        72'd7);
        chk("after rst count", 72'(a_count), 72'd1);
        hs_a;

        // Clear coinciding with ACCUM, then clear in HOLD
        a_prod  = 64'd10;
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        repeat (LAT) tick;
        chk("accum busy",  72'(a_busy),  72'd1);
        chk("accum valid", 72'(a_valid), 72'd0);
        a_clr = 1'b1;
        tick;
        a_clr = 1'b0;
        chk("clr accum valid", 72'(a_valid), 72'd1);
        chk("clr accum acc",   a_acc,        72'd10);
        chk("clr accum count", 72'(a_count), 72'd1);
        chk("clr accum ovf",   72'(a_ovf),   72'd0);
        a_clr = 1'b1;
        tick;
        a_clr = 1'b0;
        chk("clr hold valid", 72'(a_valid), 72'd1);
        chk("clr hold acc",   a_acc,        72'd0);
        chk("clr hold count", 72'(a_count), 72'd0);
        hs_a;

        // Saturation on the 65-bit accumulator
        repeat (3) run_b(64'h4000_0000_0000_0000, "sat pos");
        chk("sat3 acc", 72'(b_acc), 72'h0_C000_0000_0000_0000);
        chk("sat3 ovf", 72'(b_ovf), 72'd0);
        run_b(64'h4000_0000_0000_0000, "sat pos4");
        chk("sat4 acc", 72'(b_acc), 72'h0_FFFF_FFFF_FFFF_FFFF);
        chk("sat4 ovf", 72'(b_ovf), 72'd1);
        run_b(64'h4000_0000_0000_0000, "sat pos5");
        chk("sat5 acc",   72'(b_acc),   72'h0_FFFF_FFFF_FFFF_FFFF);
        chk("sat5 ovf",   72'(b_ovf),   72'd1);
        chk("sat5 count", 72'(b_count), 72'd5);
        b_clr = 1'b1;
        tick;
        b_clr = 1'b0;
        chk("sat clr acc",   72'(b_acc),   72'd0);
        chk("sat clr ovf",   72'(b_ovf),   72'd0);
        chk("sat clr count", 72'(b_count), 72'd0);
        repeat (2) run_b(64'h8000_0000_0000_0000, "sat neg");
        chk("neg2 acc", 72'(b_acc), 72'h1_0000_0000_0000_0000);
        chk("neg2 ovf", 72'(b_ovf), 72'd0);
        run_b(64'h8000_0000_0000_0000, "sat neg3");
        chk("neg3 acc", 72'(b_acc), 72'h1_0000_0000_0000_0000);
        chk("neg3 ovf", 72'(b_ovf), 72'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
